// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave to APB3/APB4 master bridge that decodes NUM_SLV APB slaves from HADDR[SEL_LSB +: 3].
// Optional macro APB_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT_CYC cycles without PREADY.
module ahb_apb_bridge_mslv #(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 3,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADYin,
  output logic               HREADYout,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic [ADDR_W-1:0]  PADDR,
  output logic [31:0]        PWDATA,
  output logic               PWRITE,
  output logic [NUM_SLV-1:0] PSEL,
  output logic               PENABLE,
  output logic [3:0]         PSTRB,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  typedef enum logic [2:0] {IDLE, WLAT, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [31:0]        pwdata_q;
  logic [31:0]        hrdata_q;
  logic               pwrite_q;
  logic [3:0]         pstrb_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic               hready_q;
  logic               hresp_q;
  logic [2:0]         idx_q;

  logic               accept;
  logic [2:0]         idx_in;
  logic               bad_req;
  logic [3:0]         strb_in;
  logic [NUM_SLV-1:0] dec_in;
  logic [NUM_SLV-1:0] dec_q;

  assign accept = HREADYin && HTRANS[1];
  assign idx_in = HADDR[SEL_LSB +: 3];

  // Request qualification: out-of-range slave, illegal size or misaligned address go to the error path.
  always_comb begin
    bad_req = 1'b0;
    strb_in = 4'h0;
    if (int'(idx_in) >= NUM_SLV) bad_req = 1'b1;
    case (HSIZE)
      3'd0: strb_in = 4'b0001 << HADDR[1:0];
      3'd1: begin
        strb_in = 4'b0011 << {HADDR[1], 1'b0};
        if (HADDR[0]) bad_req = 1'b1;
      end
      3'd2: begin
        strb_in = 4'hF;
        if (HADDR[1:0] != 2'b00) bad_req = 1'b1;
      end
      default: bad_req = 1'b1;
    endcase
    if (!HWRITE) strb_in = 4'h0;
  end

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
      assign dec_in[gi] = (idx_in == 3'(gi));
      assign dec_q[gi]  = (idx_q == 3'(gi));
    end
  endgenerate

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= 4'h0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      idx_q     <= 3'd0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          hresp_q   <= 1'b0;
          psel_q    <= '0;
          penable_q <= 1'b0;
          if (accept) begin
            hready_q <= 1'b0;
            if (bad_req) begin
              state_q <= ERR1;
              hresp_q <= 1'b1;
            end else begin
              paddr_q  <= HADDR;
              pwrite_q <= HWRITE;
              pstrb_q  <= strb_in;
              idx_q    <= idx_in;
              if (HWRITE) begin
                state_q <= WLAT;
              end else begin
                state_q <= SETUP;
                psel_q  <= dec_in;
              end
            end
          end else begin
            hready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WLAT: begin
          pwdata_q <= HWDATA;
          psel_q   <= dec_q;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            if (PSLVERR) begin
              state_q <= ERR1;
              hresp_q <= 1'b1;
            end else begin
              state_q  <= DONE;
              hready_q <= 1'b1;
              if (!pwrite_q) hrdata_q <= PRDATA;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= ERR1;
            hresp_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        ERR1: begin
          hready_q <= 1'b1;
          state_q  <= ERR2;
        end
        ERR2: begin
          // A transfer presented during ERR2 is dropped; the master must idle after an ERROR.
          hresp_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HREADYout = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PSTRB     = pstrb_q;

endmodule
